// File: rtl/paddle_controller.sv
// Paddle position controller: synchronises the player buttons, ramps the
// paddle speed while a button is held, and steps the registered left-edge
// position once per frame during vertical blank, clamped to the playfield.
module paddle_controller #(
  parameter int PADDLE_WIDTH = 48,
  parameter int SCREEN_WIDTH = 640,
  parameter int X_INIT       = 296,
  parameter int MAX_SPEED    = 6,
  parameter int ACCEL_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       frame_tick,
  input  logic       freeze,
  output logic [9:0] x,
  output logic [1:0] dir,
  output logic [2:0] speed
);

  localparam int          XMAX       = SCREEN_WIDTH - PADDLE_WIDTH;
  localparam logic [9:0]  XMAX10     = 10'(XMAX);
  localparam logic [10:0] XMAX11     = 11'(XMAX);
  localparam logic [9:0]  XINIT10    = 10'(X_INIT);
  localparam logic [2:0]  MAXSPD     = 3'(MAX_SPEED);
  localparam int          ACW        = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
  localparam logic [ACW-1:0] ACCEL_LAST = ACW'(ACCEL_FRAMES - 1);

  localparam logic [1:0] DIR_STILL = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    STEP   = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     leftSync_q, rightSync_q;
  logic           freeze_q, freeze_d;
  logic [1:0]     req_q, req_d;
  logic [1:0]     dir_q, dir_d;
  logic [2:0]     speed_q, speed_d;
  logic [ACW-1:0] accelCnt_q, accelCnt_d;
  logic [9:0]     x_q, x_d;
  logic [10:0]    sum;

  // Two-flop synchronisers bring the raw buttons into the clock domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      leftSync_q  <= 2'b00;
      rightSync_q <= 2'b00;
    end else begin
      leftSync_q  <= {leftSync_q[0], btn_left};
      rightSync_q <= {rightSync_q[0], btn_right};
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      freeze_q   <= 1'b0;
      req_q      <= DIR_STILL;
      dir_q      <= DIR_STILL;
      speed_q    <= 3'd0;
      accelCnt_q <= '0;
      x_q        <= XINIT10;
    end else begin
      state_q    <= state_d;
      freeze_q   <= freeze_d;
      req_q      <= req_d;
      dir_q      <= dir_d;
      speed_q    <= speed_d;
      accelCnt_q <= accelCnt_d;
      x_q        <= x_d;
    end
  end

  // Per-frame sequence: latch request, update direction/speed, then move
  always_comb begin
    state_d    = state_q;
    freeze_d   = freeze_q;
    req_d      = req_q;
    dir_d      = dir_q;
    speed_d    = speed_q;
    accelCnt_d = accelCnt_q;
    x_d        = x_q;
    sum        = {1'b0, x_q} + {8'b0, speed_q};

    case (state_q)
      IDLE: begin
        if (frame_tick) begin
          freeze_d = freeze;
          if (leftSync_q[1] && !rightSync_q[1]) begin
            req_d = DIR_LEFT;
          end else if (rightSync_q[1] && !leftSync_q[1]) begin
            req_d = DIR_RIGHT;
          end else begin
            req_d = DIR_STILL;
          end
          state_d = SAMPLE;
        end
      end

      SAMPLE: begin
        if (freeze_q || (req_q == DIR_STILL)) begin
          dir_d      = DIR_STILL;
          speed_d    = 3'd0;
          accelCnt_d = '0;
        end else if (req_q != dir_q) begin
          dir_d      = req_q;
          speed_d    = 3'd1;
          accelCnt_d = '0;
        end else if (accelCnt_q == ACCEL_LAST) begin
          accelCnt_d = '0;
          if (speed_q < MAXSPD) begin
            speed_d = speed_q + 3'd1;
          end
        end else begin
          accelCnt_d = accelCnt_q + 1'b1;
        end
        state_d = STEP;
      end

      STEP: begin
        if (dir_q == DIR_RIGHT) begin
          x_d = (sum > XMAX11) ? XMAX10 : sum[9:0];
        end else if (dir_q == DIR_LEFT) begin
          x_d = (x_q < {7'b0, speed_q}) ? 10'd0 : (x_q - {7'b0, speed_q});
        end
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign x     = x_q;
  assign dir   = dir_q;
  assign speed = speed_q;

endmodule
